// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial multi-word adder sequencer.
// Steps a WIDTH-bit add through an external 4-bit adder, one nibble per
// cycle, LSB first. The carry is held in a register between nibbles.
module nibble_serial_add_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [3:0]       adder_a,
  output logic [3:0]       adder_b,
  output logic             adder_cin,
  input  logic [3:0]       adder_s,
  input  logic             adder_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int unsigned NIB  = WIDTH / 4;
  localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              last_c;

  assign last_c = (idx_q == IDXW'(NIB - 1));

  // Present the current operand nibbles and carry to the adder during RUN only.
  always_comb begin
    adder_a   = 4'd0;
    adder_b   = 4'd0;
    adder_cin = 1'b0;
    if (state_q == RUN) begin
      adder_cin = carry_q;
      for (int i = 0; i < NIB; i++) begin
        if (idx_q == IDXW'(i)) begin
          adder_a = a_q[4*i +: 4];
          adder_b = b_q[4*i +: 4];
        end
      end
    end
  end

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NIB; i++) begin
          if (idx_q == IDXW'(i)) sum_d[4*i +: 4] = adder_s;
        end
        carry_d = adder_cout;
        idx_d   = idx_q + IDXW'(1);
        if (last_c) begin
          idx_d   = '0;
          cout_d  = adder_cout;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (adder_s[3] != a_q[WIDTH-1]);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl: a 16-bit and a 4-bit instance,
// each wired to a behavioural 4-bit adder.
module tb_nibble_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // 16-bit instance
  logic        in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, out_ovf, busy;
  logic [15:0] in_a, in_b, out_sum;
  logic [3:0]  adder_a, adder_b, adder_s;
  logic        adder_cin, adder_cout;

  assign {adder_cout, adder_s} = 5'(adder_a) + 5'(adder_b) + 5'(adder_cin);

  nibble_serial_add_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
    .adder_s(adder_s), .adder_cout(adder_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .busy(busy)
  );

  // 4-bit instance
  logic       v4, rdy4, cin4, ov4, ordy4, cout4, ovf4, busy4;
  logic [3:0] a4, b4, sum4, aa4, ab4, as4;
  logic       acin4, acout4;

  assign {acout4, as4} = 5'(aa4) + 5'(ab4) + 5'(acin4);

  nibble_serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(v4), .in_ready(rdy4),
    .in_a(a4), .in_b(b4), .in_cin(cin4),
    .adder_a(aa4), .adder_b(ab4), .adder_cin(acin4),
    .adder_s(as4), .adder_cout(acout4),
    .out_valid(ov4), .out_ready(ordy4),
    .out_sum(sum4), .out_cout(cout4), .out_ovf(ovf4), .busy(busy4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full 16-bit operation with a per-nibble adder_cin expectation.
  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic [3:0] exp_cins, input logic [15:0] exp_sum,
                       input logic exp_cout, input logic exp_ovf, input string tag);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check({tag, "_adder_cin"}, 32'(adder_cin), 32'(exp_cins[k]));
      check({tag, "_adder_a"}, 32'(adder_a), 32'((a >> (4*k)) & 16'hF));
      check({tag, "_valid_early"}, 32'(out_valid), 32'd0);
      tick();
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sum"}, 32'(out_sum), 32'(exp_sum));
    check({tag, "_cout"}, 32'(out_cout), 32'(exp_cout));
    check({tag, "_ovf"}, 32'(out_ovf), 32'(exp_ovf));
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic drain16(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_drain_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_drain_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    v4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; ordy4 = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_cout", 32'(out_cout), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_adder_a", 32'(adder_a), 32'd0);
    check("rst_adder_cin", 32'(adder_cin), 32'd0);

    run16(16'h1234, 16'h4321, 1'b0, 4'b0000, 16'h5555, 1'b0, 1'b0, "basic");
    drain16("basic");
    check("idle_sum_hold", 32'(out_sum), 32'h5555);
    check("idle_adder_a", 32'(adder_a), 32'd0);

    run16(16'hFFFF, 16'h0001, 1'b0, 4'b1110, 16'h0000, 1'b1, 1'b0, "ripple");
    drain16("ripple");
    run16(16'h7FFF, 16'h0001, 1'b0, 4'b1110, 16'h8000, 1'b0, 1'b1, "posovf");
    drain16("posovf");
    run16(16'h8000, 16'h8000, 1'b0, 4'b0000, 16'h0000, 1'b1, 1'b1, "negovf");
    drain16("negovf");
    run16(16'h0000, 16'h0000, 1'b1, 4'b0001, 16'h0001, 1'b0, 1'b0, "cin");

    // Backpressure: result held, new requests ignored.
    for (int k = 0; k < 3; k++) begin
      in_a = 16'hAAAA; in_b = 16'h5555; in_valid = 1'b1;
      tick();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_sum", 32'(out_sum), 32'h0001);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_adder_a", 32'(adder_a), 32'd0);
    end
    in_valid = 1'b0;
    drain16("hold");
    check("hold_sum_after", 32'(out_sum), 32'h0001);

    // Reset at idx==2 discards the operation.
    in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("midrun_adder_a_idx2", 32'(adder_a), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_adder_a", 32'(adder_a), 32'd0);
    check("midrst_adder_b", 32'(adder_b), 32'd0);
    check("midrst_adder_cin", 32'(adder_cin), 32'd0);
    check("midrst_sum", 32'(out_sum), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("midrst_no_result", 32'(out_valid), 32'd0);
    end
    run16(16'h0001, 16'h0001, 1'b0, 4'b0000, 16'h0002, 1'b0, 1'b0, "post_rst");
    drain16("post_rst");

    // WIDTH=4 instance: one RUN cycle.
    a4 = 4'h9; b4 = 4'h9; cin4 = 1'b0; v4 = 1'b1;
    tick();
    v4 = 1'b0;
    check("w4_adder_a", 32'(aa4), 32'h9);
    check("w4_adder_b", 32'(ab4), 32'h9);
    check("w4_busy", 32'(busy4), 32'd1);
    check("w4_valid_early", 32'(ov4), 32'd0);
    tick();
    check("w4_valid", 32'(ov4), 32'd1);
    check("w4_sum", 32'(sum4), 32'h2);
    check("w4_cout", 32'(cout4), 32'd1);
    check("w4_ovf", 32'(ovf4), 32'd1);
    ordy4 = 1'b1;
    tick();
    ordy4 = 1'b0;
    check("w4_drain_valid", 32'(ov4), 32'd0);
    check("w4_drain_ready", 32'(rdy4), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
